// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, debug/loader), the arbiter and
// the single-port memory. The arbiter takes the slave side.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_halt;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        output dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        input  dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and the
// debug/loader port; one access in flight, fixed latency of 2+MEM_LAT cycles.
//
// state | meaning
// IDLE  | sample eligible requests, latch grantee and access, raise mem_en
// ISSUE | mem_en high for this one cycle, clear latency counter
// WAIT  | count to MEM_LAT-1, then capture mem_rdata into grantee's rdata
// ACK   | grantee's ack high for one cycle, update last_gnt
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    mem_arbiter_if.slave bus
);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_check
        $error("mem_arbiter: MEM_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic       GNT_CPU = 1'b0;
    localparam logic       GNT_DBG = 1'b1;
    localparam logic [2:0] LAT_M1  = 3'(MEM_LAT - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       gnt;
    logic       last_gnt;
    logic       cpu_elig;
    logic       pick_dbg;

    assign cpu_elig = bus.cpu_req & ~bus.dbg_halt;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_dbg = 1'b0;
        if (cpu_elig && bus.dbg_req)
            pick_dbg = (last_gnt == GNT_CPU);
        else
            pick_dbg = bus.dbg_req;
    end

    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 3'd0;
            gnt           <= GNT_CPU;
            last_gnt      <= GNT_DBG;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= 32'd0;
            bus.dbg_ack   <= 1'b0;
            bus.dbg_rdata <= 32'd0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_elig || bus.dbg_req) begin
                        gnt           <= pick_dbg ? GNT_DBG : GNT_CPU;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= pick_dbg ? bus.dbg_we    : bus.cpu_we;
                        bus.mem_addr  <= pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
                        bus.mem_wdata <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Address and write data stay put so the memory sees a stable bus.
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    cnt        <= 3'd0;
                    state      <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAT_M1) begin
                        if (gnt == GNT_DBG) begin
                            bus.dbg_rdata <= bus.mem_rdata;
                            bus.dbg_ack   <= 1'b1;
                        end else begin
                            bus.cpu_rdata <= bus.mem_rdata;
                            bus.cpu_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    bus.cpu_ack <= 1'b0;
                    bus.dbg_ack <= 1'b0;
                    last_gnt    <= gnt;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// inputs driven and outputs checked around the falling clock edge.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] BAD = 32'h0BAD_0BAD;
    localparam logic [31:0] VA  = 32'hAAAA_0001;
    localparam logic [31:0] VB  = 32'hBBBB_0002;
    localparam logic [31:0] VC  = 32'hCCCC_0003;
    localparam logic [31:0] VD  = 32'hDDDD_0004;
    localparam logic [31:0] VE  = 32'h1234_5678;
    localparam logic [31:0] VF  = 32'hF00D_CAFE;

    always #5 clk = ~clk;

    mem_arbiter_if b1 ();
    mem_arbiter_if b3 ();

    mem_arbiter #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    mem_arbiter #(.MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
        b1.dbg_req = 0; b1.dbg_we = 0; b1.dbg_addr = 0; b1.dbg_wdata = 0;
        b1.dbg_halt = 0; b1.mem_rdata = 0;
        b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0;
        b3.dbg_req = 0; b3.dbg_we = 0; b3.dbg_addr = 0; b3.dbg_wdata = 0;
        b3.dbg_halt = 0; b3.mem_rdata = 0;

        // Reset state
        step(); step(); #1;
        chk("rst_cpu_ack",   b1.cpu_ack,   0);
        chk("rst_dbg_ack",   b1.dbg_ack,   0);
        chk("rst_mem_en",    b1.mem_en,    0);
        chk("rst_mem_we",    b1.mem_we,    0);
        chk("rst_mem_addr",  b1.mem_addr,  0);
        chk("rst_mem_wdata", b1.mem_wdata, 0);
        chk("rst_cpu_rdata", b1.cpu_rdata, 0);
        chk("rst_dbg_rdata", b1.dbg_rdata, 0);
        chk("rst3_mem_en",   b3.mem_en,    0);
        step(); reset = 1'b0;

        // Single CPU read, MEM_LAT=1
        step(); b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h10; b1.mem_rdata = BAD; #1;
        chk("rd_t0_mem_en", b1.mem_en, 0);
        chk("rd_t0_stall",  b1.cpu_stall, 1);
        step(); #1;
        chk("rd_t1_mem_en",   b1.mem_en, 1);
        chk("rd_t1_mem_addr", b1.mem_addr, 32'h10);
        chk("rd_t1_mem_we",   b1.mem_we, 0);
        step(); b1.mem_rdata = 32'hDEAD_BEEF; #1;
        chk("rd_t2_mem_en",  b1.mem_en, 0);
        chk("rd_t2_cpu_ack", b1.cpu_ack, 0);
        step(); b1.mem_rdata = BAD; #1;
        chk("rd_t3_cpu_ack",   b1.cpu_ack, 1);
        chk("rd_t3_cpu_rdata", b1.cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_t3_stall",     b1.cpu_stall, 0);
        chk("rd_t3_dbg_ack",   b1.dbg_ack, 0);
        step(); b1.cpu_req = 0; #1;
        chk("rd_t4_cpu_ack",   b1.cpu_ack, 0);
        chk("rd_t4_cpu_rdata", b1.cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_t4_mem_addr",  b1.mem_addr, 32'h10);

        // Reset between accesses clears read data and restores last_gnt=DBG
        step(); reset = 1'b1; #1;
        step(); reset = 1'b0; #1;
        chk("rst2_cpu_rdata", b1.cpu_rdata, 0);
        chk("rst2_mem_addr",  b1.mem_addr, 0);

        // Tie after reset: CPU, DBG, CPU
        for (int k = 0; k <= 11; k++) begin
            step();
            if (k == 0) begin
                b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h100;
                b1.dbg_req = 1; b1.dbg_we = 0; b1.dbg_addr = 32'h200;
            end
            if (k == 7) b1.dbg_req = 0;
            b1.mem_rdata = (k == 2) ? VA : (k == 6) ? VB : (k == 10) ? VC : BAD;
            #1;
            chk($sformatf("tie_mem_en_%0d", k),  b1.mem_en,  (k == 1 || k == 5 || k == 9) ? 32'd1 : 32'd0);
            chk($sformatf("tie_cpu_ack_%0d", k), b1.cpu_ack, (k == 3 || k == 11) ? 32'd1 : 32'd0);
            chk($sformatf("tie_dbg_ack_%0d", k), b1.dbg_ack, (k == 7) ? 32'd1 : 32'd0);
            if (k == 1 || k == 9) chk("tie_cpu_addr", b1.mem_addr, 32'h100);
            if (k == 5) chk("tie_dbg_addr", b1.mem_addr, 32'h200);
            if (k == 3) chk("tie_cpu_rdata_a", b1.cpu_rdata, VA);
            if (k == 7) begin
                chk("tie_dbg_rdata_b", b1.dbg_rdata, VB);
                chk("tie_cpu_rdata_hold", b1.cpu_rdata, VA);
            end
            if (k == 11) chk("tie_cpu_rdata_c", b1.cpu_rdata, VC);
        end

        // Halt blocks CPU; halt rising mid-access does not abort it
        for (int j = 0; j <= 4; j++) begin
            step();
            if (j == 0) begin b1.dbg_halt = 1; b1.cpu_addr = 32'h300; end
            #1;
            chk($sformatf("halt_mem_en_%0d", j), b1.mem_en, 0);
            chk($sformatf("halt_stall_%0d", j),  b1.cpu_stall, 1);
        end
        step(); b1.dbg_halt = 0; #1;
        chk("unhalt_t0_mem_en", b1.mem_en, 0);
        step(); #1;
        chk("unhalt_t1_mem_en",   b1.mem_en, 1);
        chk("unhalt_t1_mem_addr", b1.mem_addr, 32'h300);
        step(); b1.dbg_halt = 1; b1.mem_rdata = VD; #1;
        chk("unhalt_t2_cpu_ack", b1.cpu_ack, 0);
        step(); b1.mem_rdata = BAD; #1;
        chk("unhalt_t3_cpu_ack",   b1.cpu_ack, 1);
        chk("unhalt_t3_cpu_rdata", b1.cpu_rdata, VD);
        step(); b1.cpu_req = 0; b1.dbg_halt = 0; #1;
        chk("unhalt_t4_cpu_ack", b1.cpu_ack, 0);
        chk("unhalt_t4_mem_en",  b1.mem_en, 0);

        // Reset in WAIT abandons the access
        step(); b1.cpu_req = 1; b1.cpu_addr = 32'h40; #1;
        step(); #1;
        chk("mid_t1_mem_en",   b1.mem_en, 1);
        chk("mid_t1_mem_addr", b1.mem_addr, 32'h40);
        step(); reset = 1'b1; b1.mem_rdata = 32'h5555_AAAA; #1;
        chk("mid_t2_cpu_ack", b1.cpu_ack, 0);
        step(); reset = 1'b0; #1;
        chk("mid_t3_cpu_ack",   b1.cpu_ack, 0);
        chk("mid_t3_dbg_ack",   b1.dbg_ack, 0);
        chk("mid_t3_mem_en",    b1.mem_en, 0);
        chk("mid_t3_mem_we",    b1.mem_we, 0);
        chk("mid_t3_mem_addr",  b1.mem_addr, 0);
        chk("mid_t3_mem_wdata", b1.mem_wdata, 0);
        chk("mid_t3_cpu_rdata", b1.cpu_rdata, 0);
        chk("mid_t3_dbg_rdata", b1.dbg_rdata, 0);
        chk("mid_t3_stall",     b1.cpu_stall, 1);
        step(); #1;
        chk("mid_t4_mem_en",   b1.mem_en, 1);
        chk("mid_t4_mem_addr", b1.mem_addr, 32'h40);
        chk("mid_t4_cpu_ack",  b1.cpu_ack, 0);
        step(); b1.mem_rdata = 32'h0F0F_0F0F; #1;
        chk("mid_t5_cpu_ack", b1.cpu_ack, 0);
        step(); b1.mem_rdata = BAD; #1;
        chk("mid_t6_cpu_ack",   b1.cpu_ack, 1);
        chk("mid_t6_cpu_rdata", b1.cpu_rdata, 32'h0F0F_0F0F);
        step(); b1.cpu_req = 0; #1;
        chk("mid_t7_cpu_ack", b1.cpu_ack, 0);

        // MEM_LAT=3: debug write then CPU read
        step(); b3.dbg_req = 1; b3.dbg_we = 1; b3.dbg_addr = 32'h4; b3.dbg_wdata = 32'h5; b3.mem_rdata = BAD; #1;
        chk("wr3_t0_mem_en", b3.mem_en, 0);
        step(); #1;
        chk("wr3_t1_mem_en",    b3.mem_en, 1);
        chk("wr3_t1_mem_we",    b3.mem_we, 1);
        chk("wr3_t1_mem_addr",  b3.mem_addr, 32'h4);
        chk("wr3_t1_mem_wdata", b3.mem_wdata, 32'h5);
        step(); #1;
        chk("wr3_t2_mem_en",    b3.mem_en, 0);
        chk("wr3_t2_mem_we",    b3.mem_we, 0);
        chk("wr3_t2_mem_addr",  b3.mem_addr, 32'h4);
        chk("wr3_t2_mem_wdata", b3.mem_wdata, 32'h5);
        chk("wr3_t2_dbg_ack",   b3.dbg_ack, 0);
        step(); #1;
        chk("wr3_t3_dbg_ack", b3.dbg_ack, 0);
        step(); b3.mem_rdata = VE; #1;
        chk("wr3_t4_dbg_ack", b3.dbg_ack, 0);
        step(); b3.mem_rdata = BAD; #1;
        chk("wr3_t5_dbg_ack",   b3.dbg_ack, 1);
        chk("wr3_t5_dbg_rdata", b3.dbg_rdata, VE);
        chk("wr3_t5_cpu_ack",   b3.cpu_ack, 0);
        step(); b3.dbg_req = 0; #1;
        chk("wr3_t6_dbg_ack", b3.dbg_ack, 0);

        step(); b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 32'h8; #1;
        step(); #1;
        chk("rd3_t1_mem_en",   b3.mem_en, 1);
        chk("rd3_t1_mem_addr", b3.mem_addr, 32'h8);
        chk("rd3_t1_mem_we",   b3.mem_we, 0);
        step(); #1;
        chk("rd3_t2_cpu_ack", b3.cpu_ack, 0);
        step(); #1;
        chk("rd3_t3_cpu_ack", b3.cpu_ack, 0);
        step(); b3.mem_rdata = VF; #1;
        chk("rd3_t4_cpu_ack", b3.cpu_ack, 0);
        step(); b3.mem_rdata = BAD; #1;
        chk("rd3_t5_cpu_ack",   b3.cpu_ack, 1);
        chk("rd3_t5_cpu_rdata", b3.cpu_rdata, VF);
        chk("rd3_t5_dbg_rdata", b3.dbg_rdata, VE);
        step(); b3.cpu_req = 0; #1;
        chk("rd3_t6_cpu_ack", b3.cpu_ack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
